// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Definitions shared by the SDRAM controller and the SDRAM responder model.
//   CMD_*       : 4-bit command codes as {nCS, nRAS, nCAS, nWE}
//   err_code_t  : protocol violation codes reported by the responder
//   op_t        : decoded command class
//   MODE_*      : bit offsets of the fields in the LOAD_MODE word
//   decode_cmd  : maps CKE plus the command bits onto op_t
// No configuration macros are used in this file.
// -----------------------------------------------------------------------------
package sdram_pkg;

    localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;
    localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
    localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
    localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
    localparam logic [3:0] CMD_WRITE        = 4'b0100;
    localparam logic [3:0] CMD_READ         = 4'b0101;
    localparam logic [3:0] CMD_BURST_TERM   = 4'b0110;
    localparam logic [3:0] CMD_NOP          = 4'b0111;
    localparam logic [3:0] CMD_INHIBIT      = 4'b1111;

    localparam int MODE_BL_LSB = 0;
    localparam int MODE_BL_MSB = 2;
    localparam int MODE_CL_LSB = 4;
    localparam int MODE_CL_MSB = 6;
    localparam int MODE_AP_BIT = 10;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_NO_MODE     = 3'd1,
        ERR_BANK_CLOSED = 3'd2,
        ERR_BANK_OPEN   = 3'd3,
        ERR_TRCD        = 3'd4,
        ERR_TRFC        = 3'd5,
        ERR_REF_LATE    = 3'd6,
        ERR_BAD_MODE    = 3'd7
    } err_code_t;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_ACTIVE,
        OP_READ,
        OP_WRITE,
        OP_PRECHARGE,
        OP_REFRESH,
        OP_LOAD_MODE
    } op_t;

    // CKE low and nCS high both collapse to NOP; BURST_TERMINATE is a NOP here.
    function automatic op_t decode_cmd(input logic cke, input logic [3:0] cmd);
        op_t op;
        op = OP_NOP;
        if (cke) begin
            case (cmd)
                CMD_ACTIVE:       op = OP_ACTIVE;
                CMD_READ:         op = OP_READ;
                CMD_WRITE:        op = OP_WRITE;
                CMD_PRECHARGE:    op = OP_PRECHARGE;
                CMD_AUTO_REFRESH: op = OP_REFRESH;
                CMD_LOAD_MODE:    op = OP_LOAD_MODE;
                default:          op = OP_NOP;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/sdram_resp_bank.sv
// -----------------------------------------------------------------------------
// sdram_resp_bank
// State of one SDRAM bank: open flag, active row and the ACTIVE->READ/WRITE
// (tRCD) down-counter. The timer exists only when SDRAM_RESP_CHECK_EN is
// defined; otherwise trcd_ok_o is tied high.
// Ports:
//   clk       in  clock
//   init      in  synchronous active-high reset (closes the bank, clears timer)
//   act_i     in  ACTIVE to this bank on this edge
//   close_i   in  precharge (explicit or auto) of this bank on this edge
//   row_i     in  row address captured on ACTIVE
//   open_o    out bank is open
//   row_o     out currently active row
//   trcd_ok_o out tRCD satisfied for an access on this edge
// -----------------------------------------------------------------------------
module sdram_resp_bank
    import sdram_pkg::*;
#(
    parameter int ROW_W = 4,
    parameter int T_RCD = 2
) (
    input  logic             clk,
    input  logic             init,
    input  logic             act_i,
    input  logic             close_i,
    input  logic [ROW_W-1:0] row_i,
    output logic             open_o,
    output logic [ROW_W-1:0] row_o,
    output logic             trcd_ok_o
);

    logic             open_q, open_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        if (act_i) begin
            open_d = 1'b1;
            row_d  = row_i;
        end else if (close_i) begin
            open_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            open_q <= 1'b0;
        end else begin
            open_q <= open_d;
        end
        row_q <= row_d;
    end

    assign open_o = open_q;
    assign row_o  = row_q;

`ifdef SDRAM_RESP_CHECK_EN
    // Remaining edges until an access is legal; zero means no constraint.
    // Loading T_RCD-1 makes an access at distance d legal iff d >= T_RCD.
    localparam int TW = $clog2(T_RCD + 1);
    logic [TW-1:0] rcd_q, rcd_d;

    always_comb begin
        rcd_d = rcd_q;
        if (act_i) begin
            rcd_d = TW'(T_RCD - 1);
        end else if (rcd_q != '0) begin
            rcd_d = rcd_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            rcd_q <= '0;
        end else begin
            rcd_q <= rcd_d;
        end
    end

    assign trcd_ok_o = (rcd_q == '0);
`else
    logic unused_rcd;
    assign unused_rcd = ^32'(T_RCD);
    assign trcd_ok_o  = 1'b1;
`endif

endmodule

// File: rtl/sdram_responder.sv
// -----------------------------------------------------------------------------
// sdram_responder
// Chip-side SDRAM model: decodes the command bus, keeps per-bank open rows,
// serves single-word reads/writes from an on-chip array with CAS latency 2/3,
// and (with SDRAM_RESP_CHECK_EN defined) checks protocol timing and latches
// the first violation in err/err_code. Without the macro, err/err_code are 0.
// Ports:
//   clk, init                      clock, synchronous active-high reset
//   SDRAM_CKE, SDRAM_nCS/nRAS/nCAS/nWE, SDRAM_A, SDRAM_BA   command bus
//   SDRAM_DQML, SDRAM_DQMH          write byte masks (1 = masked)
//   sd_dq_i                         write data
//   sd_dq_o, sd_dq_oe               read data and its valid/drive enable
//   err, err_code                   sticky first-violation report
// -----------------------------------------------------------------------------
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int ROW_W   = 4,
    parameter int COL_W   = 6,
    parameter int T_RCD   = 2,
    parameter int T_RFC   = 7,
    parameter int REF_MAX = 1600
) (
    input  logic        clk,
    input  logic        init,
    input  logic        SDRAM_CKE,
    input  logic        SDRAM_nCS,
    input  logic        SDRAM_nRAS,
    input  logic        SDRAM_nCAS,
    input  logic        SDRAM_nWE,
    input  logic [12:0] SDRAM_A,
    input  logic [1:0]  SDRAM_BA,
    input  logic        SDRAM_DQML,
    input  logic        SDRAM_DQMH,
    input  logic [15:0] sd_dq_i,
    output logic [15:0] sd_dq_o,
    output logic        sd_dq_oe,
    output logic        err,
    output logic [2:0]  err_code
);

    localparam int AW    = 2 + ROW_W + COL_W;
    localparam int DEPTH = 1 << AW;

    op_t              op;
    logic             ap;
    logic [3:0]       bank_act, bank_close, bank_open, bank_trcd_ok;
    logic [ROW_W-1:0] bank_row [4];
    logic             sel_open;
    logic [AW-1:0]    addr;
    logic             rd_go, wr_go;
    logic [15:0]      rd_word;
    logic [15:0]      mem [DEPTH];

    logic             mode_legal;
    logic             mode_vld_q, mode_vld_d;
    logic             cl2_q, cl2_d;

    logic             vld_p1_q, vld_p1_d, short_p1_q, short_p1_d;
    logic [15:0]      dat_p1_q, dat_p1_d;
    logic             vld_p2_q, vld_p2_d;
    logic [15:0]      dat_p2_q, dat_p2_d;
    logic             oe_q, oe_d;
    logic [15:0]      dq_q, dq_d;

    logic             unused_a;

    assign op       = decode_cmd(SDRAM_CKE, {SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE});
    assign ap       = SDRAM_A[MODE_AP_BIT];
    assign unused_a = ^SDRAM_A;

    always_comb begin
        bank_act   = '0;
        bank_close = '0;
        for (int b = 0; b < 4; b++) begin
            if (op == OP_ACTIVE && SDRAM_BA == 2'(b)) bank_act[b] = 1'b1;
            if (op == OP_PRECHARGE && (ap || SDRAM_BA == 2'(b))) bank_close[b] = 1'b1;
            if ((op == OP_READ || op == OP_WRITE) && ap && SDRAM_BA == 2'(b)) bank_close[b] = 1'b1;
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_bank
        sdram_resp_bank #(
            .ROW_W (ROW_W),
            .T_RCD (T_RCD)
        ) u_bank (
            .clk       (clk),
            .init      (init),
            .act_i     (bank_act[b]),
            .close_i   (bank_close[b]),
            .row_i     (SDRAM_A[ROW_W-1:0]),
            .open_o    (bank_open[b]),
            .row_o     (bank_row[b]),
            .trcd_ok_o (bank_trcd_ok[b])
        );
    end

    assign sel_open = bank_open[SDRAM_BA];
    assign addr     = {SDRAM_BA, bank_row[SDRAM_BA], SDRAM_A[COL_W-1:0]};
    // Accesses to a closed bank are dropped regardless of the check build.
    assign rd_go    = (op == OP_READ)  && sel_open && !init;
    assign wr_go    = (op == OP_WRITE) && sel_open && !init;
    assign rd_word  = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_go) begin
            if (!SDRAM_DQML) mem[addr][7:0]  <= sd_dq_i[7:0];
            if (!SDRAM_DQMH) mem[addr][15:8] <= sd_dq_i[15:8];
        end
    end

    assign mode_legal = (SDRAM_A[MODE_CL_MSB:MODE_CL_LSB] == 3'd2 ||
                         SDRAM_A[MODE_CL_MSB:MODE_CL_LSB] == 3'd3) &&
                        (SDRAM_A[MODE_BL_MSB:MODE_BL_LSB] == 3'd0);

    always_comb begin
        mode_vld_d = mode_vld_q;
        cl2_d      = cl2_q;
        if (op == OP_LOAD_MODE) begin
            mode_vld_d = 1'b1;
            // Illegal modes fall back to CL=3.
            cl2_d      = mode_legal && (SDRAM_A[MODE_CL_MSB:MODE_CL_LSB] == 3'd2);
        end

        // p1: array word captured on the READ edge, tagged with its latency
        vld_p1_d   = rd_go;
        short_p1_d = cl2_q;
        dat_p1_d   = rd_word;
        // p2: extra stage taken only by CL=3 reads
        vld_p2_d   = vld_p1_q && !short_p1_q;
        dat_p2_d   = dat_p1_q;
        // output: launched at READ edge + CL-1
        oe_d       = 1'b0;
        dq_d       = '0;
        if (vld_p2_q) begin
            oe_d = 1'b1;
            dq_d = dat_p2_q;
        end else if (vld_p1_q && short_p1_q) begin
            oe_d = 1'b1;
            dq_d = dat_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            mode_vld_q <= 1'b0;
            cl2_q      <= 1'b0;
            vld_p1_q   <= 1'b0;
            short_p1_q <= 1'b0;
            vld_p2_q   <= 1'b0;
            oe_q       <= 1'b0;
            dq_q       <= '0;
        end else begin
            mode_vld_q <= mode_vld_d;
            cl2_q      <= cl2_d;
            vld_p1_q   <= vld_p1_d;
            short_p1_q <= short_p1_d;
            vld_p2_q   <= vld_p2_d;
            oe_q       <= oe_d;
            dq_q       <= dq_d;
        end
        dat_p1_q <= dat_p1_d;
        dat_p2_q <= dat_p2_d;
    end

    assign sd_dq_o  = dq_q;
    assign sd_dq_oe = oe_q;

`ifdef SDRAM_RESP_CHECK_EN
    localparam int RW = $clog2(T_RFC + 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [RW-1:0] rfc_q, rfc_d;
    logic [15:0]   ref_cnt_q, ref_cnt_d;
    logic          err_q, err_d;
    err_code_t     code_q, code_d, viol;
    logic          is_acc;

    assign is_acc = (op == OP_READ) || (op == OP_WRITE);

    always_comb begin
        // rfc_q counts edges still forbidden after AUTO_REFRESH; zero = free.
        rfc_d = rfc_q;
        if (op == OP_REFRESH) begin
            rfc_d = RW'(T_RFC - 1);
        end else if (rfc_q != '0) begin
            rfc_d = rfc_q - 1'b1;
        end

        ref_cnt_d = ref_cnt_q;
        if (op == OP_REFRESH) begin
            ref_cnt_d = '0;
        end else if (mode_vld_q) begin
            ref_cnt_d = sat_inc16(ref_cnt_q);
        end

        // Lowest code wins when several checks fire on the same edge.
        viol = ERR_NONE;
        if (is_acc && !mode_vld_q) begin
            viol = ERR_NO_MODE;
        end else if (is_acc && !sel_open) begin
            viol = ERR_BANK_CLOSED;
        end else if ((op == OP_ACTIVE && sel_open) || (op == OP_REFRESH && |bank_open)) begin
            viol = ERR_BANK_OPEN;
        end else if (is_acc && !bank_trcd_ok[SDRAM_BA]) begin
            viol = ERR_TRCD;
        end else if (op != OP_NOP && rfc_q != '0) begin
            viol = ERR_TRFC;
        end else if (mode_vld_q && op != OP_REFRESH && ref_cnt_q >= 16'(REF_MAX)) begin
            // count currently REF_MAX becomes REF_MAX+1 on this edge
            viol = ERR_REF_LATE;
        end else if (op == OP_LOAD_MODE && !mode_legal) begin
            viol = ERR_BAD_MODE;
        end

        err_d  = err_q;
        code_d = code_q;
        if (!err_q && viol != ERR_NONE) begin
            err_d  = 1'b1;
            code_d = viol;
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            rfc_q     <= '0;
            ref_cnt_q <= '0;
            err_q     <= 1'b0;
            code_q    <= ERR_NONE;
        end else begin
            rfc_q     <= rfc_d;
            ref_cnt_q <= ref_cnt_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    assign err      = err_q;
    assign err_code = code_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{bank_trcd_ok, mode_vld_q, 32'(T_RFC), 32'(REF_MAX)};
    assign err        = 1'b0;
    assign err_code   = 3'd0;
`endif

endmodule
